// File: rtl/rx_uart.sv
// UART receiver for 8N1 frames. The line is synchronised, each frame is
// sampled at mid-bit, and every completed frame ends in exactly one of: a
// byte written to the downstream FIFO, an overrun pulse, or a framing error.
module rx_uart #(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       fifo_full,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam logic [9:0]  BIT_LAST     = 10'(CLKS_PER_BIT - 1);
    localparam logic [9:0]  HALF_LAST    = 10'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    logic       rx_meta;
    logic       rx_s;
    state_e     state_q, state_d;
    logic [9:0] cnt_q, cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       ferr_q, ferr_d;
    logic       ovr_q, ovr_d;

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
        end
    end

    // State, counters, shift register and registered output strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    // Next-state logic: all sampling happens on the last count of a bit period.
    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q == BIT_LAST) ? '0 : cnt_q + 10'd1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                // A start bit that is gone by mid-bit was a glitch.
                if (cnt_q == HALF_LAST) begin
                    if (rx_s) begin
                        state_d = StIdle;
                    end else begin
                        state_d   = StData;
                        bit_idx_d = '0;
                    end
                end
            end
            StData: begin
                if (cnt_q == BIT_LAST) begin
                    shift_d[bit_idx_q] = rx_s;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            StStop: begin
                // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
                if (cnt_q == BIT_LAST) begin
                    if (rx_s) begin
                        state_d = StIdle;
                        if (!fifo_full) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StBreak;
                    end
                end
            end
            StBreak: begin
                // A line held low must not look like a new start bit.
                cnt_d = '0;
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_rx_uart.sv
// Bench for rx_uart. The bit period is scaled down (16 clocks per bit) to
// keep runs short; all expected timing is derived from the same parameters.
// Stimulus pushes the expected outcome of each frame into a queue; a monitor
// pops and checks it whenever the DUT emits a strobe.
module tb_rx_uart;

    localparam int unsigned CLK_FREQ  = 1_600_000;
    localparam int unsigned BAUD_RATE = 100_000;
    localparam int unsigned CPB       = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF      = CPB / 2;
    // Pin fall to strobe: 2 sync cycles + stop decision at HALF+9*CPB + 1 register.
    localparam int unsigned LAT       = HALF + 9 * CPB + 3;

    localparam int EV_VALID = 0;
    localparam int EV_FERR  = 1;
    localparam int EV_OVR   = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
        longint     cyc;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       rx_in;
    logic       fifo_full;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int         checks;
    int         failures;
    longint     cyc;
    logic [7:0] last_byte;
    ev_t        exp_q[$];
    ev_t        mon_e;
    int         mon_kind;

    rx_uart #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_in    (rx_in),
        .fifo_full(fifo_full),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && (rx_valid || frame_err || overrun)) begin
            check("pulse_exclusive", 32'(rx_valid) + 32'(frame_err) + 32'(overrun), 1);
            mon_kind = rx_valid ? EV_VALID : (frame_err ? EV_FERR : EV_OVR);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event: got kind %0d data %0d expected none", mon_kind,
                         rx_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_kind", 64'(mon_kind), 64'(mon_e.kind));
                check("event_cycle", 64'(cyc), 64'(mon_e.cyc));
                check("rx_data", 64'(rx_data), 64'(mon_e.data));
            end
        end
    end

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame starting now; hold_low extends a bad stop bit into a break.
    task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic full,
                              input int hold_low);
        ev_t e;
        e.cyc = cyc + LAT;
        if (stop_ok && !full) begin
            last_byte = d;
            e.kind    = EV_VALID;
        end else if (stop_ok) begin
            e.kind = EV_OVR;
        end else begin
            e.kind = EV_FERR;
        end
        e.data = last_byte;
        exp_q.push_back(e);

        fifo_full = full;
        rx_in     = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            repeat (CPB) @(negedge clk);
        end
        if (stop_ok) begin
            rx_in = 1'b1;
            repeat (CPB) @(negedge clk);
        end else begin
            rx_in = 1'b0;
            repeat (CPB + hold_low) @(negedge clk);
            rx_in = 1'b1;
            repeat (2 * CPB) @(negedge clk);
        end
        fifo_full = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rx_data"}, 64'(rx_data), 0);
        check({tag, "_rx_valid"}, 64'(rx_valid), 0);
        check({tag, "_frame_err"}, 64'(frame_err), 0);
        check({tag, "_overrun"}, 64'(overrun), 0);
        check({tag, "_busy"}, 64'(busy), 0);
    endtask

    initial begin
        logic [7:0] c3;
        int         waited;
        checks    = 0;
        failures  = 0;
        last_byte = 8'h00;
        rst       = 1'b1;
        rx_in     = 1'b1;
        fifo_full = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        idle(4);

        // Plain frame; latency is checked by the monitor.
        send_frame(8'h55, 1'b1, 1'b0, 0);
        idle(2 * CPB);

        // Short low glitch: busy rises, then falls with no strobe.
        rx_in = 1'b0;
        repeat (HALF * 2 / 3) @(negedge clk);
        check("busy_in_glitch", 64'(busy), 1);
        rx_in = 1'b1;
        repeat (HALF + 4) @(negedge clk);
        check("busy_after_glitch", 64'(busy), 0);
        idle(CPB);
        send_frame(8'hA3, 1'b1, 1'b0, 0);
        idle(2 * CPB);

        // Bad stop bit with a long break, then a good frame.
        send_frame(8'h3C, 1'b0, 1'b0, 2000);
        check("busy_after_break", 64'(busy), 0);
        send_frame(8'h81, 1'b1, 1'b0, 0);
        idle(2 * CPB);

        // Full FIFO: overrun, rx_data keeps 0x81.
        send_frame(8'h7E, 1'b1, 1'b1, 0);
        idle(2 * CPB);

        // Back-to-back frames with a single stop bit each.
        send_frame(8'h00, 1'b1, 1'b0, 0);
        send_frame(8'hFF, 1'b1, 1'b0, 0);
        send_frame(8'h5A, 1'b1, 1'b0, 0);
        idle(2 * CPB);

        // Reset during data bit 4 of 0xC3: nothing reported for it.
        c3    = 8'hC3;
        rx_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx_in = c3[i];
            repeat (CPB) @(negedge clk);
        end
        rx_in = c3[4];
        repeat (HALF) @(negedge clk);
        check("busy_before_reset", 64'(busy), 1);
        rst   = 1'b1;
        rx_in = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("midreset");
        rst       = 1'b0;
        last_byte = 8'h00;
        idle(2 * CPB);
        send_frame(8'h12, 1'b1, 1'b0, 0);
        idle(2 * CPB);

        // Randomised frames: data, FIFO state, stop errors and gaps.
        for (int n = 0; n < 24; n++) begin
            send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 7) != 0,
                       $urandom_range(0, 3) == 0, int'($urandom_range(0, 3 * CPB)));
            idle(int'($urandom_range(0, 2 * CPB)));
        end

        waited = 0;
        while (exp_q.size() != 0 && waited < 4 * LAT) begin
            @(negedge clk);
            waited++;
        end
        check("queue_drained", 64'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
